// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative RV32M multiply sequencer.
package mul_pkg;

    localparam int XLEN     = 32;
    localparam int MUL_ITER = 32;
    localparam int CNT_W    = $clog2(MUL_ITER);

    // funct3[1:0] encoding of the M-extension multiply ops
    typedef enum logic [1:0] {
        MUL_LO = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CALC   = 2'b01,
        FINISH = 2'b10
    } mul_state_e;

    // Unsigned magnitude of an operand; |0x80000000| stays 0x80000000,
    // which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic            is_signed);
        return (is_signed && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Request/response bundle between the core and the multiply sequencer.
// Handshake: the core raises i_start for one cycle while o_busy is low;
// the sequencer raises o_busy until the result is produced, then pulses
// o_valid for exactly one cycle with o_result, which holds until the
// next o_valid. i_flush aborts whatever is in flight and drops any
// request presented in the same cycle.
interface mul_sequencer_if;
    import mul_pkg::*;

    logic            i_start;
    logic [1:0]      i_mul_op;
    logic [XLEN-1:0] i_op_a;
    logic [XLEN-1:0] i_op_b;
    logic            i_flush;
    logic            o_busy;
    logic            o_valid;
    logic [XLEN-1:0] o_result;

    modport master (
        output i_start, i_mul_op, i_op_a, i_op_b, i_flush,
        input  o_busy, o_valid, o_result
    );

    modport slave (
        input  i_start, i_mul_op, i_op_a, i_op_b, i_flush,
        output o_busy, o_valid, o_result
    );

endinterface

// File: rtl/full_adder_32bit.sv
// Word-wide adder with carry in/out used by the shift-add accumulate.
module full_adder_32bit
    import mul_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            c_i,
    output logic [XLEN-1:0] s,
    output logic            c_o
);

    // Carry out lands in the extra top bit of the widened sum
    always_comb begin
        {c_o, s} = {1'b0, a} + {1'b0, b} + {{XLEN{1'b0}}, c_i};
    end

endmodule

// File: rtl/mul_sequencer.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are converted to magnitudes on load, multiplied unsigned over
// 32 iterations, and the sign is restored on the 64-bit product before
// the requested half is registered.
module mul_sequencer
    import mul_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    mul_sequencer_if.slave    bus,
    output mul_state_e        o_state
);

    mul_state_e        state_q;
    mul_state_e        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [XLEN-1:0]   acc_q;
    logic              neg_q;
    logic              sel_hi_q;
    logic              valid_q;
    logic [XLEN-1:0]   result_q;

    logic              load;
    logic              iterate;
    logic              finish;
    logic              last_iter;

    mul_op_e           op;
    logic              a_signed;
    logic              b_signed;

    logic [XLEN-1:0]   addend;
    logic [XLEN-1:0]   sum_lo;
    logic              sum_hi;
    logic [2*XLEN-1:0] prod_raw;
    logic [2*XLEN-1:0] prod;

    // Decode operand signedness from the op sampled at acceptance
    always_comb begin
        op       = mul_op_e'(bus.i_mul_op);
        a_signed = (op == MULH) || (op == MULHSU);
        b_signed = (op == MULH);
    end

    // Only the accumulate adder is shared hardware; bit 0 of the
    // multiplier decides whether the multiplicand is added this cycle.
    assign addend = mplier_q[0] ? mcand_q : '0;

    full_adder_32bit u_add (
        .a   (acc_q),
        .b   (addend),
        .c_i (1'b0),
        .s   (sum_lo),
        .c_o (sum_hi)
    );

    // Sign restoration on the full product; negating zero yields zero
    always_comb begin
        prod_raw = {acc_q, mplier_q};
        prod     = neg_q ? -prod_raw : prod_raw;
    end

    assign last_iter = (cnt_q == CNT_W'(MUL_ITER - 1));

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        if (bus.i_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.i_start) state_d = CALC;
                CALC:    if (last_iter)   state_d = FINISH;
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM-derived strobes for the datapath and the stall output
    always_comb begin
        load    = (state_q == IDLE)   && bus.i_start && !bus.i_flush;
        iterate = (state_q == CALC)   && !bus.i_flush;
        finish  = (state_q == FINISH) && !bus.i_flush;
    end

    // Operand load, shift-add iteration and result capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            sel_hi_q <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= finish;
            if (bus.i_flush) begin
                cnt_q <= '0;
            end else if (load) begin
                mcand_q  <= magnitude(bus.i_op_a, a_signed);
                mplier_q <= magnitude(bus.i_op_b, b_signed);
                neg_q    <= (a_signed & bus.i_op_a[XLEN-1]) ^ (b_signed & bus.i_op_b[XLEN-1]);
                sel_hi_q <= (op != MUL_LO);
                acc_q    <= '0;
                cnt_q    <= '0;
            end else if (iterate) begin
                // 65-bit {sum, mplier} shifted right by one
                acc_q    <= {sum_hi, sum_lo[XLEN-1:1]};
                mplier_q <= {sum_lo[0], mplier_q[XLEN-1:1]};
                cnt_q    <= cnt_q + CNT_W'(1);
            end else if (finish) begin
                result_q <= sel_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
            end
        end
    end

    assign bus.o_busy   = (state_q != IDLE);
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: a driver issues requests and pushes
// hand-computed results; a monitor pops and compares on every o_valid.
module tb_mul_sequencer;
    import mul_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    mul_state_e  dbg_state;

    mul_sequencer_if bus ();

    mul_sequencer dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .o_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every valid pops one expected result
    always @(negedge clk) begin
        if (rst_n && bus.o_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got result 0x%08h with no request outstanding", bus.o_result);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", bus.o_result, mon_exp);
            end
        end
    end

    // Issue one request; returns #1 after the edge that raises o_valid,
    // which is the earliest cycle a back-to-back request may be presented.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        int n;
        int busy_cycles;
        bus.i_mul_op = op;
        bus.i_op_a   = a;
        bus.i_op_b   = b;
        bus.i_start  = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.i_start  = 1'b0;
        bus.i_op_a   = 32'hDEAD_BEEF;
        bus.i_op_b   = 32'h1234_5678;
        busy_cycles  = bus.o_busy ? 1 : 0;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.o_valid) break;
            if (bus.o_busy) busy_cycles++;
        end
        check("latency", 32'(n), 32'd33);
        check("busy_cycles", 32'(busy_cycles), 32'd33);
        check("busy_in_valid_cycle", {31'b0, bus.o_busy}, 32'd0);
    endtask

    task automatic count_valids(input int cycles, output int nv);
        nv = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_valid) nv++;
        end
    endtask

    int nv;

    initial begin
        bus.i_start  = 1'b0;
        bus.i_flush  = 1'b0;
        bus.i_mul_op = 2'b00;
        bus.i_op_a   = '0;
        bus.i_op_b   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   {31'b0, bus.o_busy},  32'd0);
        check("reset_valid",  {31'b0, bus.o_valid}, 32'd0);
        check("reset_result", bus.o_result,         32'd0);
        check("reset_state",  32'(dbg_state),       32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic product, valid must be a single-cycle pulse
        issue(2'b00, 32'd7, 32'd6, 32'd42);
        @(posedge clk);
        #1;
        check("valid_one_cycle", {31'b0, bus.o_valid}, 32'd0);

        // Most negative operand, both signed and unsigned
        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        issue(2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);

        // All-ones operands under every signedness
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // Back-to-back: second request presented in the valid cycle
        @(negedge clk);
        issue(2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
        issue(2'b00, 32'd3, 32'd3, 32'd9);

        // Flush mid-CALC, with a start pulse during CALC that must be ignored
        @(negedge clk);
        bus.i_mul_op = 2'b00;
        bus.i_op_a   = 32'd7;
        bus.i_op_b   = 32'd6;
        bus.i_start  = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                bus.i_op_a  = 32'd2;
                bus.i_op_b  = 32'd2;
                bus.i_start = 1'b1;
            end
            if (i == 4) bus.i_start = 1'b0;
        end
        check("busy_before_flush", {31'b0, bus.o_busy}, 32'd1);
        bus.i_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        check("flush_busy",   {31'b0, bus.o_busy}, 32'd0);
        check("flush_state",  32'(dbg_state),      32'(IDLE));
        check("flush_result", bus.o_result,        32'd9);
        count_valids(40, nv);
        check("flush_no_valid", 32'(nv), 32'd0);

        // Flush together with start in IDLE drops the request
        bus.i_mul_op = 2'b00;
        bus.i_op_a   = 32'd4;
        bus.i_op_b   = 32'd4;
        bus.i_start  = 1'b1;
        bus.i_flush  = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_flush = 1'b0;
        check("flush_start_busy", {31'b0, bus.o_busy}, 32'd0);
        count_valids(40, nv);
        check("flush_start_no_valid", 32'(nv), 32'd0);
        check("flush_start_result", bus.o_result, 32'd9);

        // Asynchronous reset in the middle of CALC
        bus.i_mul_op = 2'b11;
        bus.i_op_a   = 32'd5;
        bus.i_op_b   = 32'd7;
        bus.i_start  = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy",   {31'b0, bus.o_busy},  32'd0);
        check("async_rst_valid",  {31'b0, bus.o_valid}, 32'd0);
        check("async_rst_result", bus.o_result,         32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
        repeat (3) @(posedge clk);
        #1;

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative RV32M multiply controller for the single-cycle core's M-extension path.
- Accepts one MUL/MULH/MULHSU/MULHU request and holds the core stalled via `o_busy`.
- Runs a radix-2 shift-add over 32 cycles, applies sign correction and returns the selected 32-bit half with a one-cycle `o_valid` pulse.
- Replaces a fully combinational multiplier array with one adder and a small FSM.

## Interface
- `XLEN`, 32, operand/result width; only 32 supported.
- `i_clk`  in  1  clock, rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_start`  in  1  request; sampled only in IDLE.
- `i_mul_op`  in  2  funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `i_op_a`  in  XLEN  rs1 (multiplicand).
- `i_op_b`  in  XLEN  rs2 (multiplier).
- `i_flush`  in  1  abort current operation.
- `o_busy`  out  1  state != IDLE; core stall.
- `o_valid`  out  1  result valid, one cycle.
- `o_result`  out  XLEN  selected product half, held until next valid.

## Operation
- Reset: state IDLE, counter 0, all internal registers 0, `o_busy`=0, `o_valid`=0, `o_result`=0.
- States: IDLE, CALC, FINISH.
- IDLE → CALC when `i_start`=1. Load:
  - `a_signed` = op in {MULH, MULHSU}; `b_signed` = op == MULH.
  - `mcand` = |a| when `a_signed` and a[31], else a; `mplier` = |b| likewise.
  - `neg` = (`a_signed` & a[31]) ^ (`b_signed` & b[31]); `sel_hi` = op != MUL.
  - `acc` = 0; cnt = 0.
- |0x80000000| = 0x80000000, treated as unsigned magnitude; correct.
- CALC, each cycle:
  - `sum[32:0]` = `acc` + (`mplier`[0] ? `mcand` : 0).
  - {`acc`,`mplier`} ← {`sum`,`mplier`} >> 1, a 65-bit right shift; `acc`:`mplier` form the 64-bit product.
  - cnt++; when cnt==31, go to FINISH.
- FINISH:
  - `prod` = `neg` ? −{`acc`,`mplier`} : {`acc`,`mplier`} (64-bit two's complement; −0 = 0).
  - `o_result` ← `sel_hi` ? `prod`[63:32] : `prod`[31:0].
  - `o_valid` ← 1; state → IDLE.
- `o_valid` is registered, high exactly one cycle, else 0.
- `i_start` during CALC/FINISH is ignored; no queueing.
- `i_flush` (any state, priority over all): next edge state IDLE, cnt 0, no `o_valid`, `o_result` unchanged. Flush in FINISH suppresses the valid.
- `i_flush` and `i_start` together in IDLE: flush wins, request dropped.
- Zero operands: no early exit; latency is fixed.
- Reset mid-operation: async clear to reset values, no partial result.

## Timing
- Edge E0 samples `i_start` in IDLE.
- Iterations occur on edges E1..E32.
- E33 registers `o_result`; `o_valid`=1 in the cycle after E33.
- Result latency: 33 cycles.
- `o_busy`=1 from after E0 through E33, and 0 in the `o_valid` cycle.
- A new `i_start` may be accepted in the `o_valid` cycle (back-to-back), giving a 33-cycle throughput.
- The core holds `i_op_a`, `i_op_b` and `i_mul_op` stable only at E0; everything else is registered internally.

## Structure
- `mul_pkg` holds:
  - `XLEN` constant.
  - `mul_op_e` enum (MUL_LO=2'b00, MULH=2'b01, MULHSU=2'b10, MULHU=2'b11).
  - `mul_state_e` enum (IDLE, CALC, FINISH).
  - `MUL_ITER` = 32.
- Sub-module: the CALC accumulate uses the existing `full_adder_32bit` (C_i=0; c_o is sum[32]).
- FSM, counter, negation and half-select stay in `mul_sequencer`.

## Test plan
- MUL 7×6 → `o_result`=42, `o_valid` one cycle at E33, `o_busy` high for 33 cycles.
- 0x80000000×0x80000000: MUL → 0x00000000; MULH → 0x40000000; MULHU → 0x40000000.
- 0xFFFFFFFF×0xFFFFFFFF: MUL → 0x00000001; MULH → 0x00000000; MULHSU → 0xFFFFFFFF; MULHU → 0xFFFFFFFE.
- MUL 0xFFFFFFFD(−3)×5 → 0xFFFFFFF1, then `i_start` held in the `o_valid` cycle with 3×3 → second result 9 after 33 more cycles.
- `i_flush` at E10 → no `o_valid`, `o_busy`=0 after E11, `o_result` keeps its previous value; `i_start` pulses during CALC are ignored.
- `i_rst_n` low at E15 mid-CALC → `o_busy`, `o_valid` and `o_result` are 0 immediately (async); after release, MULHU 0x10000×0x10000 → 0x00000001.
